aes_ctr_keystream_engine: RTL and testbench

- Parametrised CTR-mode front end for an external pipelined block-cipher core. Successor to the fixed AES-256 CTR wrapper.
- Generates counter blocks, prefetches keystream into a FIFO, and XORs it with an AXI-Stream payload.
- Adds a configurable counter-field width, configurable prefetch depth, in-flight flush on IV reload, and sticky counter-wrap reporting.
- Sits between the DMA-facing AXI-Stream ports and the AES core; the key is routed straight to the core.

---
 rtl/aes_ctr_pkg.sv | 24 ++
 rtl/aes_ctr_keystream_engine_fifo.sv | 43 ++++
 rtl/aes_ctr_keystream_engine.sv | 148 ++++++++++++++
 tb/tb_aes_ctr_keystream_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared types, status bit positions and the counter-increment helper for the CTR keystream engine.
package aes_ctr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int ST_RUN      = 0;
  localparam int ST_FLUSHING = 1;
  localparam int ST_WRAP     = 2;
  localparam int ST_EMPTY    = 3;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_BLK_LSB  = 16;

  // Widest block the helper handles; callers zero-extend and truncate around it.
  localparam int CTR_MAX_W = 512;

  function automatic logic [CTR_MAX_W-1:0] ctr_inc(input logic [CTR_MAX_W-1:0] blk,
                                                   input int ctr_w);
    logic [CTR_MAX_W-1:0] one, mask;
    one  = CTR_MAX_W'(1);
    mask = (one << ctr_w) - one;
    return (blk & ~mask) | ((blk + one) & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_keystream_engine_fifo.sv
// ctr_keystream_fifo: synchronous keystream prefetch FIFO, power-of-two depth, with a flush input.
module ctr_keystream_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Flush wins over a simultaneous push/pop: everything queued is stale.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/aes_ctr_keystream_engine.sv
// CTR-mode front end: issues counter blocks to a pipelined cipher core, prefetches keystream, XORs the stream.
// Optional byte-enable path under AES_CTR_TKEEP_EN.
module aes_ctr_keystream_engine
  import aes_ctr_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] cfg_iv,
  output logic [31:0]       status_register,
  output logic              core_req_valid,
  input  logic              core_req_ready,
  output logic [DATA_W-1:0] core_req_block,
  input  logic              core_rsp_valid,
  input  logic [DATA_W-1:0] core_rsp_block,
  output logic              s_axis_tready,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic [DATA_W-1:0] s_axis_tdata,
`ifdef AES_CTR_TKEEP_EN
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
`endif
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [DATA_W-1:0] ctr_q, ctr_next, ks_head, xored;
  logic [CW-1:0]     outstanding, outstanding_nx, discard, fifo_count;
  logic [CW:0]       occ;
  logic              fifo_empty, fifo_full, fifo_push, wrap_q;
  logic              req_hs, s_hs, m_hs;
  logic [15:0]       blocks_out;
  logic [31:0]       status_nx;

  assign req_hs = core_req_valid & core_req_ready;
  assign s_hs   = s_axis_tvalid & s_axis_tready;
  assign m_hs   = m_axis_tvalid & m_axis_tready;

  // Every block ever requested is either in the core, in the FIFO, or consumed.
  assign occ            = {1'b0, fifo_count} + {1'b0, outstanding};
  assign core_req_valid = (state == RUN) && (occ < (CW+1)'(FIFO_DEPTH));
  assign core_req_block = ctr_q;
  assign s_axis_tready  = (state == RUN) && !fifo_empty && (!m_axis_tvalid || m_axis_tready);

  assign ctr_next       = DATA_W'(ctr_inc(CTR_MAX_W'(ctr_q), CTR_W));
  assign outstanding_nx = outstanding + CW'(req_hs) - CW'(core_rsp_valid);
  assign fifo_push      = core_rsp_valid && (state == RUN) && !cfg_load;

  ctr_keystream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (cfg_load),
    .push      (fifo_push),
    .push_data (core_rsp_block),
    .pop       (s_hs),
    .head      (ks_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // On reload every block still inside the core belongs to the old IV and must be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ctr_q       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      outstanding <= outstanding_nx;
      if (cfg_load) begin
        ctr_q   <= cfg_iv;
        wrap_q  <= 1'b0;
        discard <= outstanding_nx;
        state   <= (outstanding_nx != '0) ? FLUSH : RUN;
      end else begin
        if (req_hs) begin
          ctr_q <= ctr_next;
          if (&ctr_q[CTR_W-1:0]) wrap_q <= 1'b1;
        end
        if (state == FLUSH && core_rsp_valid) begin
          discard <= discard - CW'(1);
          if (discard == CW'(1)) state <= RUN;
        end
      end
    end
  end

`ifdef AES_CTR_TKEEP_EN
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_keep
    assign xored[b*8 +: 8] = s_axis_tkeep[b] ? (s_axis_tdata[b*8 +: 8] ^ ks_head[b*8 +: 8]) : 8'h00;
  end
`else
  assign xored = s_axis_tdata ^ ks_head;
`endif

  always_comb begin
    status_nx                     = '0;
    status_nx[ST_RUN]             = (state == RUN);
    status_nx[ST_FLUSHING]        = (state == FLUSH);
    status_nx[ST_WRAP]            = wrap_q;
    status_nx[ST_EMPTY]           = fifo_empty;
    status_nx[ST_CNT_LSB +: 8]    = 8'(fifo_count);
    status_nx[ST_BLK_LSB +: 16]   = blocks_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tdata    <= '0;
`ifdef AES_CTR_TKEEP_EN
      m_axis_tkeep    <= '0;
`endif
      blocks_out      <= '0;
      status_register <= '0;
    end else begin
      if (s_hs) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tdata  <= xored;
`ifdef AES_CTR_TKEEP_EN
        m_axis_tkeep  <= s_axis_tkeep;
`endif
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      blocks_out      <= blocks_out + 16'(m_hs);
      status_register <= status_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_push && fifo_full));
  end

endmodule

// File: tb/tb_aes_ctr_keystream_engine.sv
// Directed bench for aes_ctr_keystream_engine with a fixed-latency core model returning NIST keystream.
module tb_aes_ctr_keystream_engine;

  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int LAT   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_load = 1'b0;
  logic [DW-1:0] cfg_iv = '0;
  logic [31:0]   status_register;
  logic          core_req_valid, core_req_ready;
  logic [DW-1:0] core_req_block;
  logic          core_rsp_valid;
  logic [DW-1:0] core_rsp_block;
  logic          s_axis_tready, s_axis_tvalid, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tready, m_axis_tvalid, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
`ifdef AES_CTR_TKEEP_EN
  logic [DW/8-1:0] s_axis_tkeep, m_axis_tkeep;
`endif

  aes_ctr_keystream_engine #(.DATA_W(DW), .CTR_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_load        (cfg_load),
    .cfg_iv          (cfg_iv),
    .status_register (status_register),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_block  (core_req_block),
    .core_rsp_valid  (core_rsp_valid),
    .core_rsp_block  (core_rsp_block),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tdata    (s_axis_tdata),
`ifdef AES_CTR_TKEEP_EN
    .s_axis_tkeep    (s_axis_tkeep),
    .m_axis_tkeep    (m_axis_tkeep),
`endif
    .m_axis_tready   (m_axis_tready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tdata    (m_axis_tdata)
  );

  // AES-256 keystream for the SP800-38A F.5.5 counter blocks; any other block gets a fixed scramble.
  function automatic logic [DW-1:0] ks_fn(input logic [DW-1:0] b);
    case (b)
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff: return 128'h0bdf7df1591716335e9a8b15c860c502;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00: return 128'h5a6e699d536119065433863c8f657b94;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01: return 128'h1bc12c9c01610d5d0d8bd6a3378eca62;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02: return 128'h2956e1c8693536b1bee99c73a31576b6;
      default: return {b[63:0], b[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endcase
  endfunction

  function automatic logic [DW-1:0] ctr_add(input logic [DW-1:0] iv, input int k);
    return {iv[127:32], iv[31:0] + 32'(k)};
  endfunction

  function automatic logic [DW-1:0] data_fn(input int i);
    return {32'(i) * 32'h9E3779B9, ~32'(i), 32'(i) << 4, 32'hC0DE0000 | 32'(i)};
  endfunction

  // Core model: fixed latency, in order, shares rst.
  logic [LAT-1:0] pv;
  logic [DW-1:0]  pb [LAT];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[LAT-2:0], core_req_valid & core_req_ready};
      pb[0] <= core_req_block;
      for (int i = 1; i < LAT; i++) pb[i] <= pb[i-1];
    end
  end
  assign core_rsp_valid = pv[LAT-1];
  assign core_rsp_block = ks_fn(pb[LAT-1]);

  int tmode = 0;
  int cyc   = 0;
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    m_axis_tready <= (tmode != 0) ? (cyc % 3 == 2) : 1'b1;
  end

  logic [DW-1:0] out_d[$];
  logic          out_l[$];
  logic [DW-1:0] req_q[$];
  int issued = 0, consumed = 0, max_occ = 0;
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      out_d.push_back(m_axis_tdata);
      out_l.push_back(m_axis_tlast);
    end
    if (core_req_valid && core_req_ready) begin
      req_q.push_back(core_req_block);
      issued++;
    end
    if (s_axis_tvalid && s_axis_tready) consumed++;
    if (issued - consumed > max_occ) max_occ = issued - consumed;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] iv);
    cfg_iv   = iv;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    logic hs;
    int n;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    n = 0;
    do begin
      @(negedge clk); hs = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 2000);
    s_axis_tvalid = 1'b0;
    if (!hs) begin
      total++; bad++;
      $display("FAIL send_timeout: got no tready after %0d cycles", n);
    end
  endtask

  task automatic wait_outs(input int n);
    int c;
    c = 0;
    while (out_d.size() < n && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    if (out_d.size() < n) begin
      total++; bad++;
      $display("FAIL out_timeout: got %0d words expected %0d", out_d.size(), n);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [DW-1:0] e;
    logic          el;
  } vec_t;

  vec_t vt[4];
  localparam logic [DW-1:0] NIST_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  initial begin
    logic [DW-1:0] ivb, ivc, ivd, d;
    int errs;

    vt[0] = '{128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 128'h601ec313775789a5b7a7f504bbf3d228, 1'b0};
    vt[1] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, 128'hf443e3ca4d62b59aca84e990cacaf5c5, 1'b0};
    vt[2] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef, 1'b0, 128'h2b0930daa23de94ce87017ba2d84988d, 1'b0};
    vt[3] = '{128'hf69f2445df4f9b17ad2b417be66c3710, 1'b1, 128'hdfc9c58db67aada613c2dd08457941a6, 1'b1};

    core_req_ready = 1'b1;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    s_axis_tdata   = '0;
`ifdef AES_CTR_TKEEP_EN
    s_axis_tkeep   = '1;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", status_register, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_req_valid", core_req_valid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    rst = 1'b0;

    // NIST SP800-38A F.5.5
    out_d.delete(); out_l.delete();
    load(NIST_IV);
    for (int k = 0; k < 4; k++) send(vt[k].d, vt[k].l);
    wait_outs(4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("nist_data%0d", k), out_d[k], vt[k].e);
      check($sformatf("nist_last%0d", k), out_l[k], vt[k].el);
    end

    // Counter wrap on the low 32-bit field
    do_reset();
    req_q.delete();
    load({96'h0011_2233_4455_6677_8899_aabb, 32'hFFFF_FFFE});
    repeat (8) @(posedge clk);
    #1;
    check("wrap_req_count", req_q.size() >= 3, 1);
    check("wrap_req0", req_q[0], {96'h0011_2233_4455_6677_8899_aabb, 32'hFFFF_FFFE});
    check("wrap_req1", req_q[1], {96'h0011_2233_4455_6677_8899_aabb, 32'hFFFF_FFFF});
    check("wrap_req2", req_q[2], {96'h0011_2233_4455_6677_8899_aabb, 32'h0000_0000});
    check("wrap_sticky", status_register[2], 1);
    load(128'h1);
    repeat (3) @(posedge clk);
    #1;
    check("wrap_cleared", status_register[2], 0);

    // Flush with three requests outstanding
    do_reset();
    core_req_ready = 1'b0;
    load(128'hAAAA_0000_1111_2222_3333_4444_0000_0010);
    core_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    core_req_ready = 1'b0;
    ivb = 128'hBBBB_5555_6666_7777_8888_9999_0000_0100;
    load(ivb);
    @(posedge clk); #1;
    check("flush_active_a", status_register[1], 1);
    repeat (2) @(posedge clk);
    #1;
    check("flush_active_b", status_register[1], 1);
    req_q.delete(); out_d.delete();
    repeat (3) @(posedge clk);
    #1;
    check("flush_done", status_register[1], 0);
    core_req_ready = 1'b1;
    d = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    send(d, 1'b0);
    wait_outs(1);
    check("flush_first_req", req_q[0], ivb);
    check("flush_out", out_d[0], d ^ ks_fn(ivb));

    // Backpressure: m_axis_tready one cycle in three, 200 words
    do_reset();
    tmode = 1;
    out_d.delete(); out_l.delete();
    ivc = 128'hC0C0_C0C0_1234_5678_9abc_def0_0000_1000;
    load(ivc);
    issued = 0; consumed = 0; max_occ = 0;
    for (int i = 0; i < 200; i++) send(data_fn(i), (i % 8) == 7);
    wait_outs(200);
    errs = 0;
    for (int i = 0; i < 200 && i < out_d.size(); i++) begin
      if (out_d[i] !== (data_fn(i) ^ ks_fn(ctr_add(ivc, i))) || out_l[i] !== ((i % 8) == 7)) errs++;
    end
    check("bp_count", out_d.size(), 200);
    check("bp_word_errs", errs, 0);
    check("bp_occupancy", max_occ <= DEPTH, 1);
    repeat (6) @(posedge clk);
    #1;
    check("bp_blocks_out", status_register[31:16], 200);
    tmode = 0;

    // Reset in the middle of a transfer
    do_reset();
    ivd = 128'hD00D_0000_0000_0000_0000_0000_0000_0020;
    load(ivd);
    send(data_fn(1), 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data_fn(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_m_tvalid", m_axis_tvalid, 0);
    check("mid_rst_req_valid", core_req_valid, 0);
    check("mid_rst_status", status_register, 0);
    req_q.delete(); out_d.delete(); out_l.delete();
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_reqs", req_q.size(), 0);
    check("idle_no_outs", out_d.size(), 0);
    check("idle_not_run", status_register[0], 0);
    s_axis_tvalid = 1'b0;
    load(ivd);
    send(data_fn(3), 1'b1);
    wait_outs(1);
    check("post_rst_out", out_d[0], data_fn(3) ^ ks_fn(ivd));

`ifdef AES_CTR_TKEEP_EN
    do_reset();
    out_d.delete();
    load(ivd);
    s_axis_tkeep = 16'h00FF;
    send(data_fn(7), 1'b0);
    wait_outs(1);
    d = data_fn(7) ^ ks_fn(ivd);
    check("tkeep_data", out_d[0], {64'h0, d[63:0]});
    check("tkeep_keep", m_axis_tkeep, 16'h00FF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
